// File: rtl/pulse_rate_counter.sv
// Detector front end: synchronises an async pulse line, applies a non-paralyzable
// dead time, counts accepted events per gate window and measures inter-event intervals.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | enable low; window, accumulator and interval held at zero
// S_ARMED | counting; next rising edge is accepted
// S_DEAD  | dead time after an accept; edges are counted as rejected
module pulse_rate_counter #(
    parameter int GATE_CYCLES = 65536,
    parameter int DEAD_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             enable,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overflow,
    output logic [CNT_W-1:0] last_interval,
    output logic [CNT_W-1:0] rejected
);

    localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [DW-1:0]    DEAD_LOAD = DW'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DEAD  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             r_s1;
    logic             r_s2;
    logic             r_prev;
    logic [GW-1:0]    r_gate;
    logic [CNT_W-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_ivl;
    logic [DW-1:0]    r_dead_cnt;
    logic [CNT_W-1:0] r_count_out;
    logic             r_count_valid;
    logic             r_overflow;
    logic [CNT_W-1:0] r_last_interval;
    logic [CNT_W-1:0] r_rejected;

    logic             w_edge;
    logic             w_run;
    logic             w_accept;
    logic             w_reject;
    logic [CNT_W-1:0] w_acc_nxt;
    logic             w_ovf_nxt;

    assign w_edge = r_s2 & ~r_prev;
    assign w_run  = enable && (r_state != S_IDLE);

    assign w_acc_nxt = (w_accept && (r_acc != CNT_MAX)) ? r_acc + 1'b1 : r_acc;
    assign w_ovf_nxt = r_ovf | (w_accept && (r_acc == CNT_MAX));

    // Dead time counts the accepting cycle, so DEAD lasts DEAD_CYCLES-1 cycles
    // (never fewer than one).
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (w_edge) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_DEAD;
                end
            end
            S_DEAD: begin
                if (w_edge) w_reject = 1'b1;
                if (r_dead_cnt <= DW'(1)) w_state_nxt = S_ARMED;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_accept    = 1'b0;
            w_reject    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_s1            <= 1'b0;
            r_s2            <= 1'b0;
            r_prev          <= 1'b0;
            r_gate          <= '0;
            r_acc           <= '0;
            r_ovf           <= 1'b0;
            r_ivl           <= '0;
            r_dead_cnt      <= '0;
            r_count_out     <= '0;
            r_count_valid   <= 1'b0;
            r_overflow      <= 1'b0;
            r_last_interval <= '0;
            r_rejected      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_s1          <= pulse_in;
            r_s2          <= r_s1;
            r_prev        <= r_s2;
            r_count_valid <= 1'b0;

            if (w_reject && (r_rejected != CNT_MAX))
                r_rejected <= r_rejected + 1'b1;

            if (!enable)
                r_dead_cnt <= '0;
            else if (w_accept)
                r_dead_cnt <= DEAD_LOAD;
            else if ((r_state == S_DEAD) && (r_dead_cnt != '0))
                r_dead_cnt <= r_dead_cnt - 1'b1;

            if (!w_run) begin
                r_gate <= '0;
                r_acc  <= '0;
                r_ovf  <= 1'b0;
                r_ivl  <= '0;
            end else begin
                if (w_accept) begin
                    r_last_interval <= r_ivl;
                    r_ivl           <= CNT_W'(1);
                end else if (r_ivl != CNT_MAX) begin
                    r_ivl <= r_ivl + 1'b1;
                end

                // The boundary cycle's own event closes out with this window.
                if (r_gate == GATE_LAST) begin
                    r_gate        <= '0;
                    r_count_out   <= w_acc_nxt;
                    r_overflow    <= w_ovf_nxt;
                    r_count_valid <= 1'b1;
                    r_acc         <= '0;
                    r_ovf         <= 1'b0;
                end else begin
                    r_gate <= r_gate + 1'b1;
                    r_acc  <= w_acc_nxt;
                    r_ovf  <= w_ovf_nxt;
                end
            end
        end
    end

    assign count_out     = r_count_out;
    assign count_valid   = r_count_valid;
    assign overflow      = r_overflow;
    assign last_interval = r_last_interval;
    assign rejected      = r_rejected;

endmodule

// File: doc/pulse_rate_counter.md
Name: pulse_rate_counter

Overview:
Receiving end of the random pulse source: a Geiger-style detector front end. It synchronises an asynchronous pulse line and detects rising edges. It applies a non-paralyzable dead time, counts accepted events over a fixed gate window, and reports the count once per window. It also measures the interval between consecutive accepted events, for rate and statistics readout by downstream logic.

Parameters:
GATE_CYCLES, 65536, length of one counting window in clk cycles (>=2)
DEAD_CYCLES, 4, cycles after an accepted event during which further edges are rejected (>=1)
CNT_W, 16, width of event count and interval outputs

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
pulse_in  input  1  asynchronous pulse line from the source
enable  input  1  counting enable; low holds block idle
count_out  output  CNT_W  event count of last completed window
count_valid  output  1  one-cycle strobe when count_out updates
overflow  output  1  set with count_valid if the window count saturated
last_interval  output  CNT_W  clk cycles between the two most recent accepted events
rejected  output  CNT_W  total edges rejected by dead time, saturating

Behaviour:
- Reset (rst high at posedge): all outputs 0; sync flops, edge register, gate counter, accumulator, interval counter and dead counter cleared; FSM -> IDLE. rst overrides enable and any in-flight event.
- Input path: 2-flop synchroniser s1->s2, then prev<=s2. edge = s2 & ~prev. pulse_in first sampled high at edge k gives edge=1 during cycle after edge k+1; the event is acted on at edge k+2. A high level counts once, regardless of width.
- FSM: IDLE, ARMED, DEAD.
  - IDLE: enable=0. Gate, accumulator and interval counters held at 0. count_out, last_interval and rejected hold. Sync chain keeps running. enable=1 -> ARMED.
  - ARMED: edge -> accept event, load dead counter with DEAD_CYCLES-1, go DEAD.
  - DEAD: edge -> rejected++ (saturate at all-ones), no accept. Dead counter decrements each cycle; on 0 -> ARMED. An edge in the ARMED cycle right after DEAD ends is accepted.
  - enable=0 in any state -> IDLE next cycle. A window in progress is discarded with no count_valid.
- Accept event: acc<=acc+1, saturating at 2^CNT_W-1; a saturated increment sets a sticky ovf_acc. last_interval<=ivl. ivl restarts at 1 on the accepting cycle. The first accepted event after enable rises reports cycles since enable.
- ivl: increments every enabled cycle, saturating at 2^CNT_W-1.
- Gate: gate_cnt runs 0..GATE_CYCLES-1 while enable=1, then wraps to 0. When gate_cnt==GATE_CYCLES-1:
  - count_out <= acc plus the event accepted that cycle, saturating; overflow <= ovf_acc or saturation that cycle; count_valid=1 for one cycle.
  - acc and ovf_acc clear.
  - An event on the boundary cycle belongs to the closing window, never the next one.
- count_valid is 0 on all other cycles. Outputs are registered; no combinational path from pulse_in to outputs.
- Dead time spans window boundaries; the DEAD state is not reset by a gate wrap.

Test Plan:
- GATE_CYCLES=100, DEAD_CYCLES=4, enable=1. Three 1-cycle pulses 20 cycles apart in window 0 -> count_valid at gate cycle 99, count_out=3, overflow=0. last_interval=20 after the 2nd and 3rd events.
- Two pulses 2 cycles apart -> one accepted, rejected=1. Pulses 4 cycles apart -> both accepted, rejected unchanged.
- Pulse held high 50 cycles -> count_out=1 for that window.
- Pulse arranged so the accept lands at gate_cnt==99 -> included in that window's count_out; next window starts at 0.
- CNT_W=3, 10 pulses spaced 6 cycles apart in one window -> count_out=7, overflow=1. Next quiet window -> count_out=0, overflow=0.
- enable dropped at gate cycle 50 with acc=2 -> no count_valid, count_out unchanged. Re-enable -> fresh 100-cycle window. rst asserted mid-window -> all outputs 0 the next cycle.
